// File: rtl/pulse_tx_pkg.sv
// Shared types and default configuration for the pulse_tx transmitter.
// The optional statistics feature is enabled by defining PULSE_TX_STAT_EN.
package pulse_tx_pkg;

  localparam int LEN_WIDTH_DEF  = 8;
  localparam int MIN_HOLD_DEF   = 2;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int FIFO_AW_DEF    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_tx_fifo.sv
// Request queue for pulse_tx: synchronous FIFO with a first-word-fall-through head.
// Push is ignored when full and pop is ignored when empty.
module pulse_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state is always updated with non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pulse_tx.sv
// Pulse transmitter: queues pulse lengths and shapes OUT so every level lasts >= MIN_HOLD cycles.
// Optional PULSE_TX_STAT_EN adds SENT_CNT and the sticky OVF_SEEN flag.
module pulse_tx
  import pulse_tx_pkg::*;
#(
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
  parameter int MIN_HOLD   = MIN_HOLD_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int FIFO_AW    = FIFO_AW_DEF
) (
  input  logic                 CLK50,
  input  logic                 RST,
  input  logic                 REQ_VALID,
  input  logic [LEN_WIDTH-1:0] REQ_LEN,
  output logic                 REQ_READY,
  output logic                 OUT,
  output logic                 BUSY
`ifdef PULSE_TX_STAT_EN
  ,
  output logic [15:0]          SENT_CNT,
  output logic                 OVF_SEEN
`endif
);

  localparam logic [LEN_WIDTH-1:0] HOLD = LEN_WIDTH'(MIN_HOLD);
  localparam logic [LEN_WIDTH-1:0] ONE  = LEN_WIDTH'(1);

  state_t               state, state_nxt;
  logic [LEN_WIDTH-1:0] cnt, cnt_nxt;
  logic                 out_q, out_nxt;
  logic                 armed;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [LEN_WIDTH-1:0] head;
  logic [LEN_WIDTH-1:0] eff_len;

  // Ready is held low through reset and for the first edge after it.
  always_ff @(posedge CLK50 or posedge RST) begin
    if (RST) armed <= 1'b0;
    else     armed <= 1'b1;
  end

  assign REQ_READY = armed && !full;
  assign push      = REQ_VALID && REQ_READY;
  assign eff_len   = (head < HOLD) ? HOLD : head;

  pulse_tx_fifo #(
    .WIDTH (LEN_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (CLK50),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .din   (REQ_LEN),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge CLK50 or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      out_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      out_q <= out_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    out_nxt   = out_q;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        out_nxt = 1'b0;
        if (!empty) begin
          pop       = 1'b1;
          cnt_nxt   = eff_len - ONE;
          out_nxt   = 1'b1;
          state_nxt = PULSE;
        end
      end
      PULSE: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - ONE;
        end else begin
          out_nxt   = 1'b0;
          cnt_nxt   = HOLD - ONE;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - ONE;
        end else if (!empty) begin
          pop       = 1'b1;
          cnt_nxt   = eff_len - ONE;
          out_nxt   = 1'b1;
          state_nxt = PULSE;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        out_nxt   = 1'b0;
      end
    endcase
  end

  assign OUT  = out_q;
  assign BUSY = (state != IDLE) || !empty;

`ifdef PULSE_TX_STAT_EN
  always_ff @(posedge CLK50 or posedge RST) begin
    if (RST) begin
      SENT_CNT <= '0;
      OVF_SEEN <= 1'b0;
    end else begin
      if (state == PULSE && cnt == '0) SENT_CNT <= SENT_CNT + 16'd1;
      if (REQ_VALID && full)           OVF_SEEN <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pulse_tx.sv
// Directed self-checking bench for pulse_tx: one instance with MIN_HOLD=2, one with MIN_HOLD=3.
// Build with PULSE_TX_STAT_EN defined to also exercise SENT_CNT and OVF_SEEN.
module tb_pulse_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid, ready, out, busy;
  logic [7:0] len;
  logic       valid3, ready3, out3, busy3;
  logic [7:0] len3;
`ifdef PULSE_TX_STAT_EN
  logic [15:0] sent, sent3;
  logic        ovf, ovf3;
`endif

  int n_vec = 0;
  int n_err = 0;

  pulse_tx dut (
    .CLK50     (clk),
    .RST       (rst),
    .REQ_VALID (valid),
    .REQ_LEN   (len),
    .REQ_READY (ready),
    .OUT       (out),
    .BUSY      (busy)
`ifdef PULSE_TX_STAT_EN
    ,
    .SENT_CNT  (sent),
    .OVF_SEEN  (ovf)
`endif
  );

  pulse_tx #(.MIN_HOLD(3)) dut3 (
    .CLK50     (clk),
    .RST       (rst),
    .REQ_VALID (valid3),
    .REQ_LEN   (len3),
    .REQ_READY (ready3),
    .OUT       (out3),
    .BUSY      (busy3)
`ifdef PULSE_TX_STAT_EN
    ,
    .SENT_CNT  (sent3),
    .OVF_SEEN  (ovf3)
`endif
  );

  always #5 clk = ~clk;

  // Run-length monitors: completed high runs and low runs, sampled on the falling edge.
  int   highs[$], lows[$], highs3[$], lows3[$];
  int   run = 0, run3 = 0;
  logic prev = 1'b0, prev3 = 1'b0;

  always @(negedge clk) begin
    if (out === prev) run <= run + 1;
    else begin
      if (prev) highs.push_back(run);
      else      lows.push_back(run);
      prev <= out;
      run  <= 1;
    end
  end

  always @(negedge clk) begin
    if (out3 === prev3) run3 <= run3 + 1;
    else begin
      if (prev3) highs3.push_back(run3);
      else       lows3.push_back(run3);
      prev3 <= out3;
      run3  <= 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offers one request and returns 1 time unit after the accepting edge.
  task automatic push(input logic [7:0] l);
    int guard = 0;
    valid = 1'b1;
    len   = l;
    @(negedge clk);
    while (!ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("push_ready", ready, 1);
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("idle_timeout", busy, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hb, lb, hr;
    rst = 1'b1; valid = 1'b0; len = '0; valid3 = 1'b0; len3 = '0;

    // Reset state
    #12;
    check("rst_out", out, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 0);
    check("rst_ready3", ready3, 0);
    @(negedge clk) rst = 1'b0;
    #1 check("ready_before_edge", ready, 0);
    tick(1);
    check("ready_after_edge", ready, 1);

    // Single request of 5 with MIN_HOLD=2
    push(8'd5);
    check("t1_out_at_accept", out, 0);
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check($sformatf("t1_out_k%0d", k), out, (k <= 5) ? 1 : 0);
      check($sformatf("t1_busy_k%0d", k), busy, (k <= 7) ? 1 : 0);
    end
    check("t1_high", highs[highs.size()-1], 5);

    // MIN_HOLD=3: lengths 0 and 1 are both stretched to 3
    valid3 = 1'b1; len3 = 8'd0;
    @(negedge clk) check("t2_ready_a", ready3, 1);
    @(posedge clk) #1 len3 = 8'd1;
    @(negedge clk) check("t2_ready_b", ready3, 1);
    @(posedge clk) #1 valid3 = 1'b0;
    tick(20);
    check("t2_npulses", highs3.size(), 2);
    check("t2_high0", highs3[0], 3);
    check("t2_high1", highs3[1], 3);
    check("t2_gap", lows3[1], 3);
    check("t2_busy", busy3, 0);

    // Five requests of 4 against a 4-deep queue
    wait_idle();
    hb = highs.size();
    lb = lows.size();
    for (int i = 0; i < 5; i++) push(8'd4);
    check("t3_ready_full", ready, 0);
    valid = 1'b1; len = 8'd9;
    tick(1);
    check("t3_ready_held", ready, 0);
    valid = 1'b0;
    tick(45);
    check("t3_npulses", highs.size() - hb, 5);
    for (int i = 0; i < 5; i++) check($sformatf("t3_high%0d", i), highs[hb+i], 4);
    for (int i = 0; i < 4; i++) check($sformatf("t3_gap%0d", i), lows[lb+1+i], 2);
    check("t3_busy", busy, 0);
`ifdef PULSE_TX_STAT_EN
    check("t3_sent", sent, 6);
    check("t3_ovf", ovf, 1);
`endif

    // Push and pop on the same edge with two queued; order 5,3,7,4
    hb = highs.size();
    lb = lows.size();
    push(8'd5);
    push(8'd3);
    push(8'd7);
    tick(5);
    check("t4_count_before", dut.u_fifo.count, 2);
    push(8'd4);
    check("t4_count_after", dut.u_fifo.count, 2);
    tick(40);
    check("t4_npulses", highs.size() - hb, 4);
    check("t4_len0", highs[hb], 5);
    check("t4_len1", highs[hb+1], 3);
    check("t4_len2", highs[hb+2], 7);
    check("t4_len3", highs[hb+3], 4);
    for (int i = 0; i < 3; i++) check($sformatf("t4_gap%0d", i), lows[lb+1+i], 2);
`ifdef PULSE_TX_STAT_EN
    check("t4_sent", sent, 10);
    check("t4_ovf_sticky", ovf, 1);
`endif

    // Reset in the 3rd cycle of a length-6 pulse with two queued
    wait_idle();
    push(8'd6);
    push(8'd4);
    push(8'd4);
    tick(1);
    #2 rst = 1'b1;
    #1;
    check("t5_out_async", out, 0);
    check("t5_busy", busy, 0);
    check("t5_ready", ready, 0);
`ifdef PULSE_TX_STAT_EN
    check("t5_sent", sent, 0);
    check("t5_ovf", ovf, 0);
`endif
    tick(1);
    check("t5_out_held", out, 0);
    @(negedge clk) rst = 1'b0;
    #1 check("t5_ready_release", ready, 0);
    tick(1);
    check("t5_ready_edge", ready, 1);
    hr = highs.size();
    tick(30);
    check("t5_no_pulses", highs.size(), hr);
    check("t5_out_idle", out, 0);
    check("t5_busy_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
